// File: rtl/cnn_mac_pipe.sv
// -----------------------------------------------------------------------------
// cnn_mac_pipe
//
// Streaming multiply-accumulate for CNN dot products. Each beat multiplies an
// activation (din0) by a weight (din1). Products are summed over a run of beats
// that in_first opens and in_last closes. The closed sum is rounded, shifted
// down by FRAC_SHIFT, saturated to DOUT_WIDTH and presented for one cycle.
//
// Handshake: there is no backpressure. On every rising edge with ce=1, a beat
// is accepted if in_valid=1. in_first and in_last only mean something on an
// accepted beat. When ce=0 the whole pipeline freezes, and that includes a
// pending out_valid. out_valid is a single-cycle pulse in the enabled-cycle
// domain. dout and out_sat keep their value until the next result.
//
// Pipeline (edges counted from the edge that accepts the last beat):
//   edge 0 .. MUL_STAGES-1 : product register chain plus valid/first/last
//   edge MUL_STAGES        : accumulator (load on first or empty, else add)
//   edge MUL_STAGES+1      : rounding register (ACC_WIDTH+1 bits)
//   edge MUL_STAGES+2      : saturation / output register -> out_valid
//
// Parameters:
//   DIN0_WIDTH  signed width of din0
//   DIN1_WIDTH  signed width of din1
//   ACC_WIDTH   signed accumulator width (>= DIN0_WIDTH+DIN1_WIDTH)
//   DOUT_WIDTH  signed output width (<= ACC_WIDTH)
//   FRAC_SHIFT  right shift from accumulator to output (0..ACC_WIDTH-1)
//   MUL_STAGES  product pipeline registers (1..4)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   ce         clock enable for every register
//   in_valid   din0/din1 carry a beat
//   in_first   beat opens a new dot product
//   in_last    beat closes the dot product
//   din0       signed activation
//   din1       signed weight
//   out_valid  one enabled-cycle pulse when dout/out_sat are new
//   dout       rounded, saturated result
//   out_sat    dout was clipped
// -----------------------------------------------------------------------------
module cnn_mac_pipe #(
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 10,
    parameter int ACC_WIDTH  = 32,
    parameter int DOUT_WIDTH = 14,
    parameter int FRAC_SHIFT = 6,
    parameter int MUL_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_sat
);

    localparam int PW      = DIN0_WIDTH + DIN1_WIDTH;
    localparam int LAST_ST = MUL_STAGES - 1;
    // Bit position of the rounding half. It is only used when FRAC_SHIFT > 0.
    localparam int RND_BIT = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    // Number of rounded bits that must all agree for the value to fit in dout.
    localparam int TOP_W   = ACC_WIDTH - DOUT_WIDTH + 2;

    // -------------------------------------------------------------------------
    // Full-width signed product. Both operands are sign-extended to PW first,
    // so a PW x PW multiply truncated to PW bits gives the exact product.
    // -------------------------------------------------------------------------
    logic [PW-1:0] din0_ext;
    logic [PW-1:0] din1_ext;
    logic [PW-1:0] mul_d;

    assign din0_ext = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
    assign din1_ext = {{DIN0_WIDTH{din1[DIN1_WIDTH-1]}}, din1};
    assign mul_d    = $signed(din0_ext) * $signed(din1_ext);

    // -------------------------------------------------------------------------
    // Product pipeline with sideband. first/last are qualified with in_valid
    // at entry, so later stages never see a stray flag on a bubble.
    // -------------------------------------------------------------------------
    logic [PW-1:0]         prod_q [MUL_STAGES];
    logic [MUL_STAGES-1:0] pv_q;
    logic [MUL_STAGES-1:0] pf_q;
    logic [MUL_STAGES-1:0] pl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_q[i] <= '0;
            end
            pv_q <= '0;
            pf_q <= '0;
            pl_q <= '0;
        end else if (ce) begin
            prod_q[0] <= mul_d;
            pv_q[0]   <= in_valid;
            pf_q[0]   <= in_valid & in_first;
            pl_q[0]   <= in_valid & in_last;
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
                pv_q[i]   <= pv_q[i-1];
                pf_q[i]   <= pf_q[i-1];
                pl_q[i]   <= pl_q[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Accumulator. empty_q is set after a closing beat, so a following beat
    // that lacks in_first still starts a fresh sum. The sum wraps modulo
    // 2^ACC_WIDTH.
    // -------------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] prod_acc;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 empty_q;
    logic                 empty_d;
    logic                 acc_done_q;
    logic                 acc_done_d;

    assign prod_acc = ACC_WIDTH'($signed(prod_q[LAST_ST]));

    always_comb begin
        acc_d      = acc_q;
        empty_d    = empty_q;
        acc_done_d = 1'b0;
        if (pv_q[LAST_ST]) begin
            if (pf_q[LAST_ST] || empty_q) begin
                acc_d = prod_acc;
            end else begin
                acc_d = acc_q + prod_acc;
            end
            empty_d    = pl_q[LAST_ST];
            acc_done_d = pl_q[LAST_ST];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            empty_q    <= 1'b1;
            acc_done_q <= 1'b0;
        end else if (ce) begin
            acc_q      <= acc_d;
            empty_q    <= empty_d;
            acc_done_q <= acc_done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Rounding. This stage is one bit wider than the accumulator, so adding
    // the half can never wrap. It reads acc_q while the accumulator may
    // already be loading the next dot product, which lets back-to-back dot
    // products run with no gap.
    // -------------------------------------------------------------------------
    logic signed [ACC_WIDTH:0] acc_wide;
    logic signed [ACC_WIDTH:0] rnd_half;
    logic signed [ACC_WIDTH:0] rnd_sum;
    logic        [ACC_WIDTH:0] rnd_d;
    logic        [ACC_WIDTH:0] rnd_q;
    logic                      rnd_vld_q;

    always_comb begin
        acc_wide = (ACC_WIDTH+1)'($signed(acc_q));
        rnd_half = '0;
        if (FRAC_SHIFT > 0) begin
            rnd_half[RND_BIT] = 1'b1;
        end
        rnd_sum = acc_wide + rnd_half;
        rnd_d   = rnd_sum >>> FRAC_SHIFT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rnd_q     <= '0;
            rnd_vld_q <= 1'b0;
        end else if (ce) begin
            rnd_vld_q <= acc_done_q;
            if (acc_done_q) begin
                rnd_q <= rnd_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Saturation. The rounded value fits in DOUT_WIDTH bits exactly when every
    // bit from the top down to the dout sign bit is equal. Otherwise it clamps
    // toward the sign of the rounded value.
    // -------------------------------------------------------------------------
    logic [TOP_W-1:0]      rnd_top;
    logic                  sat_d;
    logic [DOUT_WIDTH-1:0] dout_d;
    logic                  out_valid_q;
    logic [DOUT_WIDTH-1:0] dout_q;
    logic                  out_sat_q;

    always_comb begin
        rnd_top = rnd_q[ACC_WIDTH:DOUT_WIDTH-1];
        sat_d   = !((&rnd_top) || !(|rnd_top));
        dout_d  = rnd_q[DOUT_WIDTH-1:0];
        if (sat_d) begin
            if (rnd_q[ACC_WIDTH]) begin
                dout_d = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
            end else begin
                dout_d = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            out_sat_q   <= 1'b0;
        end else if (ce) begin
            out_valid_q <= rnd_vld_q;
            if (rnd_vld_q) begin
                dout_q    <= dout_d;
                out_sat_q <= sat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_cnn_mac_pipe
//
// Directed and randomized bench for cnn_mac_pipe at its default parameters.
// A behavioural model applies the dot-product rules to each accepted beat:
// start from the product on first or when empty, otherwise add; 32-bit wrap;
// round, shift and clamp on last. It pushes {due_cycle, sat, dout} entries
// onto exp_q. A negedge monitor pops one entry per enabled cycle that shows
// out_valid, and compares value, saturation flag and enabled-cycle latency.
// -----------------------------------------------------------------------------
module tb_cnn_mac_pipe;

    localparam int D0  = 14;
    localparam int D1  = 10;
    localparam int AW  = 32;
    localparam int DW  = 14;
    localparam int FS  = 6;
    localparam int MS  = 2;
    localparam int LAT = MS + 2;
    localparam int EW  = 32 + 1 + DW;

    logic          clk;
    logic          reset;
    logic          ce;
    logic          in_valid;
    logic          in_first;
    logic          in_last;
    logic [D0-1:0] din0;
    logic [D1-1:0] din1;
    logic          out_valid;
    logic [DW-1:0] dout;
    logic          out_sat;

    cnn_mac_pipe #(
        .DIN0_WIDTH(D0),
        .DIN1_WIDTH(D1),
        .ACC_WIDTH (AW),
        .DOUT_WIDTH(DW),
        .FRAC_SHIFT(FS),
        .MUL_STAGES(MS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .in_valid (in_valid),
        .in_first (in_first),
        .in_last  (in_last),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid),
        .dout     (dout),
        .out_sat  (out_sat)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int en_cyc = 0;
    always @(posedge clk) begin
        if (ce) en_cyc <= en_cyc + 1;
    end

    // ---------------- scoreboard state ----------------
    int             pass_cnt = 0;
    int             chk_cnt  = 0;
    logic [EW-1:0]  exp_q[$];
    logic [EW-1:0]  mon_e;
    int             m_acc    = 0;
    bit             m_empty  = 1'b1;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model for one accepted beat.
    task automatic model_beat(input int a, input int b, input bit f, input bit l);
        longint p;
        longint r;
        longint half;
        int     due;
        bit     s;
        p = longint'(a) * longint'(b);
        if (f || m_empty) m_acc = int'(p);
        else              m_acc = m_acc + int'(p);
        m_empty = l;
        if (l) begin
            half = (FS > 0) ? (longint'(1) << (FS - 1)) : 0;
            r    = (longint'(m_acc) + half) >>> FS;
            s    = 1'b0;
            if (r > (longint'(1) << (DW - 1)) - 1) begin
                r = (longint'(1) << (DW - 1)) - 1;
                s = 1'b1;
            end else if (r < -(longint'(1) << (DW - 1))) begin
                r = -(longint'(1) << (DW - 1));
                s = 1'b1;
            end
            // This beat is accepted at the coming edge (en_cyc+1). The result
            // appears LAT enabled edges after that.
            due = en_cyc + 1 + LAT;
            exp_q.push_back({due[31:0], s, r[DW-1:0]});
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && ce && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("dout", $signed(dout), $signed(mon_e[DW-1:0]));
                check("out_sat", out_sat, mon_e[DW]);
                check("latency", en_cyc, mon_e[EW-1:DW+1]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input bit f, input bit l, input int a,
                        input int b, input bit c);
        in_valid = v;
        in_first = f;
        in_last  = l;
        din0     = a[D0-1:0];
        din1     = b[D1-1:0];
        ce       = c;
        if (c && v) model_beat(a, b, f, l);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) idle();
        idle();
        idle();
        check(tag, exp_q.size(), 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset    = 1'b0;
        ce       = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        din0     = '0;
        din1     = '0;

        // Asynchronous reset, checked before any clock edge.
        #1 reset = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", $signed(dout), 0);
        check("rst_out_sat", out_sat, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_acc   = 0;
        m_empty = 1'b1;

        // Single beat: 300 rounded >>6 = 5.
        step(1, 1, 1, 100, 3, 1);
        drain("drain_single");
        check("single_dout", $signed(dout), 5);
        check("single_sat", out_sat, 0);
        check("single_pulse_end", out_valid, 0);

        // Three beats: 175000 -> 2734.
        step(1, 1, 0, 1000, 100, 1);
        step(1, 0, 0, 1000, 100, 1);
        step(1, 0, 1, -500, 50, 1);
        drain("drain_three");
        check("three_dout", $signed(dout), 2734);
        check("three_sat", out_sat, 0);

        // Positive saturation over ten beats.
        for (int i = 0; i < 10; i++) step(1, i == 0, i == 9, 8191, 511, 1);
        drain("drain_possat");
        check("possat_dout", $signed(dout), 8191);
        check("possat_sat", out_sat, 1);

        // Negative saturation, then a back-to-back single beat.
        step(1, 1, 1, -8192, 511, 1);
        step(1, 1, 1, 100, 3, 1);
        drain("drain_negsat");
        check("b2b_dout", $signed(dout), 5);
        check("b2b_sat", out_sat, 0);

        // Stalls and bubbles inside the three-beat sum. The bubble carries
        // first/last that must be ignored.
        step(1, 1, 0, 1000, 100, 1);
        step(0, 1, 1, 7, 7, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1000, 100, 0);
        step(1, 0, 0, 1000, 100, 1);
        step(0, 0, 1, 3, 3, 1);
        step(1, 0, 1, -500, 50, 1);
        for (int i = 0; i < 4; i++) idle();
        // The result is now up. A stall must hold the pulse.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        check("stall_hold_valid", out_valid, 1);
        drain("drain_stall");
        check("stall_dout", $signed(dout), 2734);

        // Reset mid dot product discards the partial sum.
        step(1, 1, 0, 1000, 100, 1);
        step(1, 0, 0, 1000, 100, 1);
        reset = 1'b1;
        exp_q.delete();
        m_acc   = 0;
        m_empty = 1'b1;
        #2;
        check("midrst_dout", $signed(dout), 0);
        check("midrst_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        // After reset the accumulator is empty, so a last-only beat starts at zero.
        step(1, 0, 1, 100, 3, 1);
        drain("drain_after_rst");
        check("after_rst_dout", $signed(dout), 5);
        step(1, 1, 1, 100, 3, 1);
        drain("drain_after_rst2");
        check("after_rst2_dout", $signed(dout), 5);

        // Random stream: bubbles, stalls, random first/last, full-range operands.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 16383)) - 8192,
                 int'($urandom_range(0, 1023)) - 512,
                 $urandom_range(0, 7) != 0);
        end
        // Close any open sum so the final partial also produces a result.
        step(1, 0, 1, 8191, 511, 1);
        drain("drain_random");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
